// File: rtl/fe_seq_pkg.sv
// -----------------------------------------------------------------------------
// fe_seq_pkg
// Shared types and constants for the Fe frame transfer sequencer.
//   state_t  : sequencer states IDLE -> REQ <-> REL -> SEN -> CLR -> IDLE
//   PH_A/B/C : one-hot phase codes {C,B,A} (idle / transferring / end-of-frame)
//   phase_of : state to phase decode
// -----------------------------------------------------------------------------
package fe_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        SEN,
        CLR
    } state_t;

    localparam logic [2:0] PH_A = 3'b001;
    localparam logic [2:0] PH_B = 3'b010;
    localparam logic [2:0] PH_C = 3'b100;

    function automatic logic [2:0] phase_of(input state_t s);
        logic [2:0] ph;
        case (s)
            IDLE:     ph = PH_A;
            REQ, REL: ph = PH_B;
            default:  ph = PH_C;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/fe_sync.sv
// -----------------------------------------------------------------------------
// fe_sync
// STAGES-deep single-bit synchroniser, asynchronous active-low reset to 0.
// STAGES = 0 makes it a plain wire for inputs that are already synchronous.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronised output
// -----------------------------------------------------------------------------
module fe_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_pass
            // Clock and reset have no load in passthrough mode.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst_n;
            assign o_q = i_d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= i_d;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign o_q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/fe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fe_seq_ctrl
// Fe frame transfer sequencer. On frame enable runs NBITS four-phase dt/ack
// bit transfers, then waits for the sender acknowledge, pulses cclear and
// returns to idle. Dropping fe mid-frame aborts with a sticky err flag.
//
// Optional build macro: FE_SEQ_TIMEOUT_EN -- adds an ack/senack watchdog that
// aborts a frame stuck in REQ/REL/SEN for TIMEOUT_CYC cycles.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   fe      : frame enable (level, asynchronous)
//   ack     : per-bit receiver acknowledge (four-phase, asynchronous)
//   senack  : sender end-of-frame acknowledge (four-phase, asynchronous)
//   phase   : one-hot {C,B,A}: A idle, B transferring, C end-of-frame
//   dt      : data-transfer request for the current bit
//   bit_idx : index of the bit currently being transferred
//   cclear  : one-cycle counter/channel clear pulse
//   busy    : frame in progress (any non-IDLE state)
//   done    : one-cycle pulse on normal frame completion
//   err     : sticky abort/timeout flag, cleared on next frame start
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
// -----------------------------------------------------------------------------
module fe_seq_ctrl
    import fe_seq_pkg::*;
#(
    parameter int unsigned NBITS       = 4,
    parameter int unsigned CNT_W       = (NBITS > 1) ? $clog2(NBITS) : 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fe,
    input  logic             ack,
    input  logic             senack,
    output logic [2:0]       phase,
    output logic             dt,
    output logic [CNT_W-1:0] bit_idx,
    output logic             cclear,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic w_fe_s;
    logic w_ack_s;
    logic w_senack_s;

    fe_sync #(.STAGES(SYNC_STAGES)) u_sync_fe (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (fe),
        .o_q     (w_fe_s)
    );

    fe_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (ack),
        .o_q     (w_ack_s)
    );

    fe_sync #(.STAGES(SYNC_STAGES)) u_sync_senack (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (senack),
        .o_q     (w_senack_s)
    );

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [2:0]       r_phase;
    logic             r_dt;
    logic             r_cclear;
    logic             r_busy;
    logic             r_done;

    logic             w_abort;
    logic             w_timeout;
    logic             w_last;
    logic             w_clr_entry;

    assign w_last = (r_idx == CNT_W'(NBITS - 1));

    // -------------------------------------------------------------------------
    // Optional watchdog
    // -------------------------------------------------------------------------
`ifdef FE_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd;
    logic            w_wd_active;

    assign w_wd_active = (r_state == REQ) || (r_state == REL) || (r_state == SEN);
    // r_wd holds the number of cycles already spent in the state, so the
    // TIMEOUT_CYC-th cycle is the one that sees TIMEOUT_CYC-1.
    assign w_timeout   = w_wd_active && (r_wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wd <= '0;
        end else if (w_wd_active && !w_timeout) begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_abort     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fe_s) begin
                    w_state_nxt = REQ;
                    w_idx_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            REQ: begin
                if (!w_fe_s || w_timeout) begin
                    w_abort = 1'b1;
                end else if (w_ack_s) begin
                    w_state_nxt = REL;
                end
            end
            REL: begin
                if (!w_fe_s || w_timeout) begin
                    w_abort = 1'b1;
                end else if (!w_ack_s) begin
                    if (w_last) begin
                        w_state_nxt = SEN;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            SEN: begin
                if (!w_fe_s || w_timeout) begin
                    w_abort = 1'b1;
                end else if (w_senack_s) begin
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                if (!w_senack_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides whatever handshake arrived in the same cycle.
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    assign w_clr_entry = (w_state_nxt == CLR) && (r_state != CLR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_phase  <= PH_A;
            r_dt     <= 1'b0;
            r_cclear <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
            r_phase  <= phase_of(w_state_nxt);
            r_dt     <= (w_state_nxt == REQ);
            r_cclear <= w_clr_entry || w_abort;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_clr_entry;
        end
    end

    assign phase   = r_phase;
    assign dt      = r_dt;
    assign bit_idx = r_idx;
    assign cclear  = r_cclear;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_fe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fe_seq_ctrl
// Self-checking bench for fe_seq_ctrl.
//   u_dut4 : NBITS=4, SYNC_STAGES=2, TIMEOUT_CYC=16 -- vector table + corners
//   u_dut7 : NBITS=7, SYNC_STAGES=0 -- full frame with an ack follower
//   u_dut1 : NBITS=1, SYNC_STAGES=0 -- full frame with an ack follower
// -----------------------------------------------------------------------------
module tb_fe_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // NBITS=4 instance
    logic       fe, ack, senack;
    logic [2:0] phase;
    logic       dt, cclear, busy, done, err;
    logic [1:0] bit_idx;

    // Small instances: index 0 = NBITS 7, index 1 = NBITS 1
    logic [1:0] fe_a, ack_a, sen_a;
    logic [1:0] dt_a, cc_a, busy_a, done_a, err_a;
    logic [2:0] ph7, ph1;
    logic [2:0] idx7;
    logic [0:0] idx1;

    fe_seq_ctrl #(.NBITS(4), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) u_dut4 (
        .clk(clk), .reset(rst_n), .fe(fe), .ack(ack), .senack(senack),
        .phase(phase), .dt(dt), .bit_idx(bit_idx), .cclear(cclear),
        .busy(busy), .done(done), .err(err)
    );

    fe_seq_ctrl #(.NBITS(7), .SYNC_STAGES(0), .TIMEOUT_CYC(16)) u_dut7 (
        .clk(clk), .reset(rst_n), .fe(fe_a[0]), .ack(ack_a[0]), .senack(sen_a[0]),
        .phase(ph7), .dt(dt_a[0]), .bit_idx(idx7), .cclear(cc_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .err(err_a[0])
    );

    fe_seq_ctrl #(.NBITS(1), .SYNC_STAGES(0), .TIMEOUT_CYC(16)) u_dut1 (
        .clk(clk), .reset(rst_n), .fe(fe_a[1]), .ack(ack_a[1]), .senack(sen_a[1]),
        .phase(ph1), .dt(dt_a[1]), .bit_idx(idx1), .cclear(cc_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .err(err_a[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        fe;
        logic        ack;
        logic        sen;
        int unsigned nwait;
        logic [2:0]  ph;
        logic        dt;
        logic [1:0]  idx;
        logic        busy;
        logic        cc;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic f, input logic a, input logic s,
                       input int unsigned w, input logic [2:0] p, input logic d,
                       input logic [1:0] ix, input logic b, input logic c,
                       input logic dn, input logic e);
        vec_t v;
        v.name = n; v.fe = f; v.ack = a; v.sen = s; v.nwait = w;
        v.ph = p; v.dt = d; v.idx = ix; v.busy = b; v.cc = c; v.done = dn; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic check_u4(input string n, input logic [2:0] p, input logic d,
                            input logic [1:0] ix, input logic b, input logic c,
                            input logic dn, input logic e);
        check($sformatf("%s.phase", n), 32'(phase), 32'(p));
        check($sformatf("%s.dt", n), 32'(dt), 32'(d));
        check($sformatf("%s.bit_idx", n), 32'(bit_idx), 32'(ix));
        check($sformatf("%s.busy", n), 32'(busy), 32'(b));
        check($sformatf("%s.cclear", n), 32'(cclear), 32'(c));
        check($sformatf("%s.done", n), 32'(done), 32'(dn));
        check($sformatf("%s.err", n), 32'(err), 32'(e));
    endtask

    // Full frame on a SYNC_STAGES=0 instance: ack follows dt, senack is raised
    // in end-of-frame phase and dropped together with fe once done is seen.
    task automatic run_small(input int k, input int nb, input string nm);
        int         pulses = 0;
        int         dones  = 0;
        int         maxidx = 0;
        int         idx;
        logic       prev_dt = 1'b0;
        logic       seen_done = 1'b0;
        logic       finished = 1'b0;
        logic [2:0] ph;
        @(negedge clk);
        fe_a[k] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            ph  = (k == 0) ? ph7 : ph1;
            idx = (k == 0) ? int'(idx7) : int'(idx1);
            if (dt_a[k] && !prev_dt) pulses++;
            prev_dt = dt_a[k];
            if (done_a[k]) begin
                dones++;
                seen_done = 1'b1;
            end
            if (idx > maxidx) maxidx = idx;
            if (seen_done && ph == 3'b001) begin
                finished = 1'b1;
                break;
            end
            ack_a[k] = dt_a[k];
            sen_a[k] = (ph == 3'b100) && !seen_done;
            if (seen_done) fe_a[k] = 1'b0;
        end
        check($sformatf("%s.frame_complete", nm), 32'(finished), 32'd1);
        check($sformatf("%s.dt_pulses", nm), 32'(pulses), 32'(nb));
        check($sformatf("%s.final_idx", nm), 32'(idx), 32'(nb - 1));
        check($sformatf("%s.max_idx", nm), 32'(maxidx), 32'(nb - 1));
        check($sformatf("%s.done_pulses", nm), 32'(dones), 32'd1);
        check($sformatf("%s.err", nm), 32'(err_a[k]), 32'd0);
        check($sformatf("%s.busy", nm), 32'(busy_a[k]), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic cc_seen;

        rst_n = 1'b0;
        fe = 1'b0; ack = 1'b0; senack = 1'b0;
        fe_a = '0; ack_a = '0; sen_a = '0;

        //   name            fe ack sen w  phase  dt idx busy cc done err
        add("idle",          0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0, 0);
        add("fe_sync",       1, 0, 0, 2, 3'b001, 0, 0, 0, 0, 0, 0);
        add("req0",          1, 0, 0, 1, 3'b010, 1, 0, 1, 0, 0, 0);
        add("rel0",          1, 1, 0, 3, 3'b010, 0, 0, 1, 0, 0, 0);
        add("req1",          1, 0, 0, 3, 3'b010, 1, 1, 1, 0, 0, 0);
        add("rel1",          1, 1, 0, 3, 3'b010, 0, 1, 1, 0, 0, 0);
        add("req2",          1, 0, 0, 3, 3'b010, 1, 2, 1, 0, 0, 0);
        add("rel2",          1, 1, 0, 3, 3'b010, 0, 2, 1, 0, 0, 0);
        add("req3",          1, 0, 0, 3, 3'b010, 1, 3, 1, 0, 0, 0);
        add("rel3",          1, 1, 0, 3, 3'b010, 0, 3, 1, 0, 0, 0);
        add("sen",           1, 0, 0, 3, 3'b100, 0, 3, 1, 0, 0, 0);
        add("sen_ack_hi",    1, 1, 0, 3, 3'b100, 0, 3, 1, 0, 0, 0);
        add("sen_ack_lo",    1, 0, 0, 3, 3'b100, 0, 3, 1, 0, 0, 0);
        add("sen_wait",      1, 0, 1, 2, 3'b100, 0, 3, 1, 0, 0, 0);
        add("clr_entry",     1, 0, 1, 1, 3'b100, 0, 3, 1, 1, 1, 0);
        add("clr_hold",      1, 0, 1, 1, 3'b100, 0, 3, 1, 0, 0, 0);
        add("idle_b2b",      1, 0, 0, 3, 3'b001, 0, 3, 0, 0, 0, 0);
        add("req_b2b",       1, 0, 0, 1, 3'b010, 1, 0, 1, 0, 0, 0);
        add("f2_rel0",       1, 1, 0, 3, 3'b010, 0, 0, 1, 0, 0, 0);
        add("f2_req1",       1, 0, 0, 3, 3'b010, 1, 1, 1, 0, 0, 0);
        add("f2_rel1",       1, 1, 0, 3, 3'b010, 0, 1, 1, 0, 0, 0);
        add("f2_req2",       1, 0, 0, 3, 3'b010, 1, 2, 1, 0, 0, 0);
        add("abort_sync",    0, 0, 0, 2, 3'b010, 1, 2, 1, 0, 0, 0);
        add("abort",         0, 0, 0, 1, 3'b001, 0, 2, 0, 1, 0, 1);
        add("abort_after",   0, 0, 0, 1, 3'b001, 0, 2, 0, 0, 0, 1);
        add("restart_sync",  1, 0, 0, 2, 3'b001, 0, 2, 0, 0, 0, 1);
        add("restart",       1, 0, 0, 1, 3'b010, 1, 0, 1, 0, 0, 0);

        // Power-on reset values
        repeat (3) @(posedge clk);
        #1;
        check_u4("por", 3'b001, 0, 0, 0, 0, 0, 0);
        check("por.u7.phase", 32'(ph7), 32'h1);
        check("por.u7.bit_idx", 32'(idx7), 32'h0);
        check("por.u1.phase", 32'(ph1), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames on the NBITS=4 instance
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            fe = vecs[i].fe; ack = vecs[i].ack; senack = vecs[i].sen;
            repeat (vecs[i].nwait) @(posedge clk);
            #1;
            check_u4(vecs[i].name, vecs[i].ph, vecs[i].dt, vecs[i].idx,
                     vecs[i].busy, vecs[i].cc, vecs[i].done, vecs[i].err);
        end

        // Leave the frame and start a fresh one for the reset test
        @(negedge clk);
        fe = 1'b0; ack = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        fe = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_pre.dt", 32'(dt), 32'd1);

        // Reset mid-frame with fe=1, ack=1: immediate return, no cclear pulse
        @(negedge clk);
        ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check_u4("rst_async", 3'b001, 0, 0, 0, 0, 0, 0);
        cc_seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (cclear) cc_seen = 1'b1;
        end
        check_u4("rst_hold", 3'b001, 0, 0, 0, 0, 0, 0);
        check("rst_hold.no_cclear", 32'(cc_seen), 32'd0);

        // Release: fe already high, dt rises on the third edge
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b0;
        @(posedge clk); #1;
        check("rst_rel_e1.dt", 32'(dt), 32'd0);
        @(posedge clk); #1;
        check("rst_rel_e2.dt", 32'(dt), 32'd0);
        @(posedge clk); #1;
        check("rst_rel_e3.dt", 32'(dt), 32'd1);
        check("rst_rel_e3.phase", 32'(phase), 32'h2);

        // Ack withheld in REQ: count cycles with dt high
        cnt = 1;
        while (dt && cnt < 1000) begin
            @(posedge clk); #1;
            if (dt) cnt++;
        end
`ifdef FE_SEQ_TIMEOUT_EN
        check("timeout.req_cycles", 32'(cnt), 32'd16);
        check("timeout.phase", 32'(phase), 32'h1);
        check("timeout.err", 32'(err), 32'd1);
        check("timeout.cclear", 32'(cclear), 32'd1);
        check("timeout.done", 32'(done), 32'd0);
`else
        check("no_timeout.req_cycles", 32'(cnt), 32'd1000);
        check("no_timeout.phase", 32'(phase), 32'h2);
        check("no_timeout.err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        fe = 1'b0;
        repeat (4) @(posedge clk);

        // NBITS=7 and NBITS=1 with unsynchronised inputs
        run_small(0, 7, "n7");
        run_small(1, 1, "n1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
